// File: rtl/thermostat_core.sv
// Thermostat datapath: moving-average smoothing, saturating set-point,
// hysteresis heat/cool FSM with over-temperature alarm, registered display mux.
module thermostat_core #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned AVG_LOG2    = 3,
    parameter int unsigned HYST        = 2,
    parameter int unsigned SET_MIN     = 10,
    parameter int unsigned SET_MAX     = 40,
    parameter int unsigned SET_DEFAULT = 22,
    parameter int unsigned ALARM_HI    = 50
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_c,
    input  logic              set_up,
    input  logic              set_dn,
    input  logic [1:0]        mode_sel,
    output logic [DATA_W-1:0] display,
    output logic [DATA_W-1:0] avg_c,
    output logic              avg_valid,
    output logic [DATA_W-1:0] setpoint,
    output logic              heat_on,
    output logic              cool_on,
    output logic              alarm
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = DATA_W + AVG_LOG2;
    localparam int unsigned CMP_W = DATA_W + 2;
    localparam logic signed [CMP_W-1:0] HYST_S = CMP_W'(HYST);

    // One-hot-style encoding so heat_on/cool_on are direct state register bits.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAT = 2'b01,
        S_COOL = 2'b10
    } state_t;

    logic [DATA_W-1:0]   buf_q [DEPTH];
    logic [SUM_W-1:0]    sum_q;
    logic [AVG_LOG2-1:0] ptr_q;
    logic [DATA_W-1:0]   raw_q, peak_q;
    logic                avg_valid_q, avg_upd_q;
    logic [DATA_W-1:0]   setpoint_q, setpoint_d;
    logic [DATA_W-1:0]   display_q, display_d;
    logic                alarm_q, alarm_d;
    state_t              state_q;

    logic signed [CMP_W-1:0] avg_s, sp_s, sp_lo_s, sp_hi_s;

    assign avg_c     = sum_q[SUM_W-1:AVG_LOG2];
    assign avg_valid = avg_valid_q;
    assign setpoint  = setpoint_q;
    assign display   = display_q;
    assign alarm     = alarm_q;
    assign heat_on   = state_q[0];
    assign cool_on   = state_q[1];

    assign avg_s   = $signed({2'b00, avg_c});
    assign sp_s    = $signed({2'b00, setpoint_q});
    assign sp_lo_s = sp_s - HYST_S;
    assign sp_hi_s = sp_s + HYST_S;

    // Moving-average buffer; the first sample after reset fills every entry.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            sum_q       <= '0;
            ptr_q       <= '0;
            raw_q       <= '0;
            peak_q      <= '0;
            avg_valid_q <= 1'b0;
            avg_upd_q   <= 1'b0;
        end else begin
            avg_upd_q <= sample_valid;
            if (sample_valid) begin
                raw_q <= sample_c;
                if (sample_c > peak_q) peak_q <= sample_c;
                if (!avg_valid_q) begin
                    for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= sample_c;
                    sum_q       <= SUM_W'(sample_c) << AVG_LOG2;
                    avg_valid_q <= 1'b1;
                end else begin
                    sum_q        <= sum_q + SUM_W'(sample_c) - SUM_W'(buf_q[ptr_q]);
                    buf_q[ptr_q] <= sample_c;
                    ptr_q        <= ptr_q + AVG_LOG2'(1);
                end
            end
        end
    end

    always_comb begin
        setpoint_d = setpoint_q;
        if (set_up && !set_dn && (setpoint_q < DATA_W'(SET_MAX)))
            setpoint_d = setpoint_q + DATA_W'(1);
        else if (set_dn && !set_up && (setpoint_q > DATA_W'(SET_MIN)))
            setpoint_d = setpoint_q - DATA_W'(1);
    end

    always_comb begin
        alarm_d = alarm_q;
        if (avg_upd_q) begin
            if (avg_c >= DATA_W'(ALARM_HI))
                alarm_d = 1'b1;
            else if (avg_c < DATA_W'(ALARM_HI - HYST))
                alarm_d = 1'b0;
        end
    end

    always_comb begin
        display_d = raw_q;
        case (mode_sel)
            2'd1:    display_d = avg_c;
            2'd2:    display_d = setpoint_q;
            2'd3:    display_d = peak_q;
            default: display_d = raw_q;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            setpoint_q <= DATA_W'(SET_DEFAULT);
            display_q  <= '0;
            alarm_q    <= 1'b0;
        end else begin
            setpoint_q <= setpoint_d;
            display_q  <= display_d;
            alarm_q    <= alarm_d;
        end
    end

    // Hysteresis FSM; an active alarm pins the state to COOL.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= S_IDLE;
        end else if (avg_upd_q && avg_valid_q) begin
            if (alarm_d) begin
                state_q <= S_COOL;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (avg_s < sp_lo_s)      state_q <= S_HEAT;
                        else if (avg_s > sp_hi_s) state_q <= S_COOL;
                    end
                    S_HEAT:  if (avg_s >= sp_s) state_q <= S_IDLE;
                    S_COOL:  if (avg_s <= sp_s) state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
